timer_regs: RTL and testbench

// - Memory-mapped register front end for the timing block; sits between the core's peripheral bus and the timer.
// - Drives the timer controls: ro_trig_start, ro_trig_halt, ro_mode, ro_termcount.
// - Reads back the timer results: rf_status, rf_currcount, rf_int.
// - Latches timer events into a sticky interrupt flag and drives a maskable irq to the core.

---
 rtl/timer_regs.sv | 162 ++++++++++++++++
 tb/tb_timer_regs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : timer_regs
// Description : Memory-mapped register front end for the timer. Decodes
//               CTRL / TERM / COUNT / INTSTAT on bus_addr[3:2], issues
//               start/halt pulses, latches timer events into a sticky
//               PEND flag and drives a maskable registered irq.
//               Optional byte-enable support: define TIMER_REGS_BE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_regs #(
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] TERM_RST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
`ifdef TIMER_REGS_BE_EN
    input  logic [3:0]        bus_be,
`endif
    output logic [31:0]       bus_rdata,
    output logic              bus_ready,
    output logic              ro_trig_start,
    output logic              ro_trig_halt,
    output logic              ro_mode,
    output logic [31:0]       ro_termcount,
    input  logic              rf_status,
    input  logic [31:0]       rf_currcount,
    input  logic              rf_int,
    output logic              irq
);

    localparam logic [1:0] c_ADDR_CTRL    = 2'd0;
    localparam logic [1:0] c_ADDR_TERM    = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT   = 2'd2;
    localparam logic [1:0] c_ADDR_INTSTAT = 2'd3;

    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_start;
    logic        r_halt;
    logic        r_mode;
    logic        r_ie;
    logic        r_pend;
    logic        r_irq;
    logic        r_int_d;
    logic [31:0] r_term;

    logic [1:0]  w_idx;
    logic [3:0]  w_be;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_term;
    logic        w_w1c;
    logic        w_rise;
    logic [31:0] w_term_next;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr;

    // Byte-address bits below the word boundary are never decoded.
    assign w_unused_addr = ^bus_addr;

`ifdef TIMER_REGS_BE_EN
    assign w_be = bus_be;
`else
    assign w_be = 4'hF;
`endif

    assign w_idx     = bus_addr[3:2];
    assign w_wr      = bus_sel &  bus_we;
    assign w_rd      = bus_sel & ~bus_we;
    // CTRL fields and the INTSTAT clear bit all live in byte lane 0.
    assign w_wr_ctrl = w_wr & (w_idx == c_ADDR_CTRL) & w_be[0];
    assign w_wr_term = w_wr & (w_idx == c_ADDR_TERM);
    assign w_w1c     = w_wr & (w_idx == c_ADDR_INTSTAT) & w_be[0] & bus_wdata[0];
    assign w_rise    = rf_int & ~r_int_d;

    // Lane-merged TERM value: disabled lanes keep their current contents.
    always_comb begin
        w_term_next = r_term;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_term_next[i*8 +: 8] = bus_wdata[i*8 +: 8];
            end
        end
    end

    // Read-data selection for the access being accepted this cycle.
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_idx)
            c_ADDR_CTRL:    w_rd_mux = {23'h0, rf_status, 4'h0, r_ie, r_mode, 2'b00};
            c_ADDR_TERM:    w_rd_mux = r_term;
            c_ADDR_COUNT:   w_rd_mux = rf_currcount;
            c_ADDR_INTSTAT: w_rd_mux = {31'h0, r_pend};
            default:        w_rd_mux = 32'h0;
        endcase
    end

    // Bus response: one-cycle ready, registered read data, zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= bus_sel;
            r_rdata <= w_rd ? w_rd_mux : 32'h0;
        end
    end

    // Control registers and start/halt pulses; halt has priority over start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start <= 1'b0;
            r_halt  <= 1'b0;
            r_mode  <= 1'b0;
            r_ie    <= 1'b0;
            r_term  <= TERM_RST;
        end else begin
            r_start <= w_wr_ctrl & bus_wdata[0] & ~bus_wdata[1];
            r_halt  <= w_wr_ctrl & bus_wdata[1];
            if (w_wr_ctrl) begin
                r_mode <= bus_wdata[2];
                r_ie   <= bus_wdata[3];
            end
            if (w_wr_term) begin
                r_term <= w_term_next;
            end
        end
    end

    // Event edge detect, sticky PEND (set beats W1C) and registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_int_d <= 1'b0;
            r_pend  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_int_d <= rf_int;
            if (w_rise) begin
                r_pend <= 1'b1;
            end else if (w_w1c) begin
                r_pend <= 1'b0;
            end
            r_irq <= r_pend & r_ie;
        end
    end

    assign bus_rdata     = r_rdata;
    assign bus_ready     = r_ready;
    assign ro_trig_start = r_start;
    assign ro_trig_halt  = r_halt;
    assign ro_mode       = r_mode;
    assign ro_termcount  = r_term;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_regs
// Description : Directed self-checking bench for timer_regs. Expected read
//               data is queued when an access is driven and compared when
//               bus_ready is sampled on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_regs;

    logic        clk;
    logic        reset;
    logic        bus_sel;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
`ifdef TIMER_REGS_BE_EN
    logic [3:0]  bus_be;
`endif
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic        ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;
    logic        irq;

    int          checks;
    int          failures;
    logic [31:0] expq[$];

    timer_regs #(
        .ADDR_W   (4),
        .TERM_RST (32'hFFFF_FFFF)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus_sel       (bus_sel),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
`ifdef TIMER_REGS_BE_EN
        .bus_be        (bus_be),
`endif
        .bus_rdata     (bus_rdata),
        .bus_ready     (bus_ready),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, score any due response, idle the bus.
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ready", {31'h0, bus_ready}, 32'h1);
            chk("rdata", bus_rdata, e);
        end else begin
            chk("idle_ready", {31'h0, bus_ready}, 32'h0);
        end
        bus_sel = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic access(input logic we, input logic [1:0] idx,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        bus_sel   = 1'b1;
        bus_we    = we;
        bus_addr  = {idx, 2'b00};
        bus_wdata = wd;
        expq.push_back(exp_rd);
        cyc();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'h0;
`ifdef TIMER_REGS_BE_EN
        bus_be    = 4'hF;
`endif
        rf_status    = 1'b0;
        rf_currcount = 32'h0;
        rf_int       = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state of every output
        chk("rst_ready", {31'h0, bus_ready}, 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        chk("rst_start", {31'h0, ro_trig_start}, 32'h0);
        chk("rst_halt",  {31'h0, ro_trig_halt}, 32'h0);
        chk("rst_mode",  {31'h0, ro_mode}, 32'h0);
        chk("rst_term",  ro_termcount, 32'hFFFF_FFFF);
        chk("rst_irq",   {31'h0, irq}, 32'h0);

        // Register reads after reset
        access(1'b0, 2'd0, 32'h0, 32'h0);
        access(1'b0, 2'd1, 32'h0, 32'hFFFF_FFFF);
        access(1'b0, 2'd3, 32'h0, 32'h0);

        // TERM then START+MODE
        access(1'b1, 2'd1, 32'h10, 32'h0);
        access(1'b1, 2'd0, 32'h5, 32'h0);
        chk("start_pulse", {31'h0, ro_trig_start}, 32'h1);
        chk("start_nohalt", {31'h0, ro_trig_halt}, 32'h0);
        chk("mode_set", {31'h0, ro_mode}, 32'h1);
        chk("term_10", ro_termcount, 32'h10);
        cyc();
        chk("start_end", {31'h0, ro_trig_start}, 32'h0);
        rf_status = 1'b1;
        access(1'b0, 2'd0, 32'h0, 32'h104);

        // Mid-run TERM write: visible at once, no halt
        access(1'b1, 2'd1, 32'h55, 32'h0);
        chk("midrun_term", ro_termcount, 32'h55);
        chk("midrun_nohalt", {31'h0, ro_trig_halt}, 32'h0);

        // COUNT is read-only and sampled on the access cycle
        rf_currcount = 32'h1234;
        access(1'b0, 2'd2, 32'h0, 32'h1234);
        access(1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0);
        rf_currcount = 32'h99;
        access(1'b0, 2'd2, 32'h0, 32'h99);
        access(1'b0, 2'd1, 32'h0, 32'h55);

        // Interrupt: IE=1 (keep MODE), then a rising event
        access(1'b1, 2'd0, 32'hC, 32'h0);
        rf_int = 1'b1;
        cyc();
        chk("irq_lag", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_set", {31'h0, irq}, 32'h1);
        access(1'b0, 2'd3, 32'h0, 32'h1);
        access(1'b1, 2'd3, 32'h1, 32'h0);
        cyc();
        chk("irq_clr", {31'h0, irq}, 32'h0);
        // rf_int still high: no new edge, PEND stays clear
        access(1'b0, 2'd3, 32'h0, 32'h0);
        rf_int = 1'b0;
        cyc();
        // Rise coincident with W1C: set wins
        rf_int = 1'b1;
        access(1'b1, 2'd3, 32'h1, 32'h0);
        access(1'b0, 2'd3, 32'h0, 32'h1);
        // Writing 0 to INTSTAT has no effect
        access(1'b1, 2'd3, 32'h0, 32'h0);
        access(1'b0, 2'd3, 32'h0, 32'h1);
        cyc();
        chk("irq_again", {31'h0, irq}, 32'h1);
        // IE=0 masks irq but keeps PEND
        access(1'b1, 2'd0, 32'h4, 32'h0);
        cyc();
        chk("irq_masked", {31'h0, irq}, 32'h0);
        access(1'b0, 2'd3, 32'h0, 32'h1);
        access(1'b0, 2'd0, 32'h0, 32'h104);

        // START and HALT together: only halt pulses
        access(1'b1, 2'd0, 32'h3, 32'h0);
        chk("halt_pulse", {31'h0, ro_trig_halt}, 32'h1);
        chk("halt_nostart", {31'h0, ro_trig_start}, 32'h0);
        chk("halt_mode0", {31'h0, ro_mode}, 32'h0);
        cyc();
        chk("halt_end", {31'h0, ro_trig_halt}, 32'h0);

`ifdef TIMER_REGS_BE_EN
        // Byte-lane TERM write
        access(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0);
        bus_be = 4'b0011;
        access(1'b1, 2'd1, 32'hAABB_CCDD, 32'h0);
        chk("be_term", ro_termcount, 32'hFFFF_CCDD);
        // W1C without lane 0 does not clear PEND
        bus_be = 4'b1110;
        access(1'b1, 2'd3, 32'h1, 32'h0);
        bus_be = 4'hF;
        access(1'b0, 2'd3, 32'h0, 32'h1);
`endif

        // Reset asserted while a read is in flight: no ready issued
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 4'h4;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        bus_sel = 1'b0;
        chk("mid_rst_ready", {31'h0, bus_ready}, 32'h0);
        chk("mid_rst_rdata", bus_rdata, 32'h0);
        chk("mid_rst_term", ro_termcount, 32'hFFFF_FFFF);
        chk("mid_rst_mode", {31'h0, ro_mode}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        reset  = 1'b1;
        rf_int = 1'b0;
        cyc();
        access(1'b0, 2'd3, 32'h0, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
